hazard_stall_unit: RTL and testbench

Pipeline control block facing the ID/EX pipeline register from the control side. It detects read-after-write and load-use hazards, selects operand forwarding sources, and sequences stalls, bubbles and branch/jump flushes. It drives the hold and bubble controls of the IF/ID and ID/EX registers and the EX-stage operand muxes. One instance per core.

---
 rtl/hazard_stall_unit_pkg.sv | 23 ++
 rtl/hazard_stall_unit_fwd.sv | 26 ++
 rtl/hazard_stall_unit.sv | 214 +++++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared opcodes, forwarding-select encodings and the
// hazard FSM state type for the hazard/stall control slice.
package hazard_stall_unit_pkg;

  // RV32 major opcodes seen in the EX stage
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // EX-stage operand mux select encodings
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  // Hazard sequencer states
  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10
  } hazard_state_e;

endpackage

// File: rtl/hazard_stall_unit_fwd.sv
// fwd_select_unit: forwarding source select for one decode source register.
// The youngest producer (EX) wins over MEM; x0 is never forwarded.
module fwd_select_unit
  import hazard_stall_unit_pkg::*;
(
  input  logic [4:0] src_reg,
  input  logic [4:0] ex_rd,
  input  logic       ex_write,
  input  logic [4:0] mem_rd,
  input  logic       mem_write,
  output logic [1:0] fwd_sel
);

  // Pick the closest in-flight producer of src_reg, else the register file
  always_comb begin
    fwd_sel = FWD_REGFILE;
    if (ex_write && (ex_rd != 5'd0) && (ex_rd == src_reg)) begin
      fwd_sel = FWD_EX;
    end else if (mem_write && (mem_rd != 5'd0) && (mem_rd == src_reg)) begin
      fwd_sel = FWD_MEM;
    end else begin
      fwd_sel = FWD_REGFILE;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / RAW hazard detection, operand forwarding
// selects, and stall/bubble/flush sequencing for the ID/EX boundary.
// Build option HAZARD_FWD_EN: when defined, EX/MEM results are forwarded and
// only load-use stalls; when undefined, every RAW match stalls until the
// producer has left MEM and the forwarding selects stay at the register file.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int FLUSH_CYCLES = 2
)
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs1,
  input  logic [4:0]              id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [6:0]              ex_opcode,
  input  logic [4:0]              ex_rd,
  input  logic                    ex_write,
  input  logic [4:0]              mem_rd,
  input  logic                    mem_write,
  input  logic                    ex_redirect,
  input  logic [ADDRESS_BITS-1:0] ex_redirect_target,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    bubble_ex,
  output logic                    flush_id,
  output logic [1:0]              fwd_rs1_sel,
  output logic [1:0]              fwd_rs2_sel,
  output logic                    pc_load,
  output logic [ADDRESS_BITS-1:0] pc_load_target,
  output logic [15:0]             stall_count
);

  // Reject configurations the sequencer cannot represent
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || DATA_WIDTH < 1 || CORE < 0) begin : g_cfg_check
    $error("hazard_stall_unit: unsupported parameter set");
  end

  // Counter value loaded on a redirect: bubbles still owed after this cycle
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  hazard_state_e           state_r, state_s;
  logic [1:0]              flush_cnt_r, flush_cnt_s;
  logic                    pc_load_r;
  logic [ADDRESS_BITS-1:0] pc_target_r;
  logic [15:0]             stall_count_r;
  logic [1:0]              sel_rs1_s, sel_rs2_s;
  logic                    load_use_s, hazard_s;
  logic                    stall_s, bubble_s, flush_s;

  // The same comparators serve forwarding and RAW detection
  fwd_select_unit u_fwd_rs1 (
    .src_reg   (id_rs1),
    .ex_rd     (ex_rd),
    .ex_write  (ex_write),
    .mem_rd    (mem_rd),
    .mem_write (mem_write),
    .fwd_sel   (sel_rs1_s)
  );

  fwd_select_unit u_fwd_rs2 (
    .src_reg   (id_rs2),
    .ex_rd     (ex_rd),
    .ex_write  (ex_write),
    .mem_rd    (mem_rd),
    .mem_write (mem_write),
    .fwd_sel   (sel_rs2_s)
  );

  // A load in EX whose destination is read by decode (EX match implies rd != 0)
  assign load_use_s = id_valid && (ex_opcode == OPC_LOAD) &&
                      ((id_uses_rs1 && (sel_rs1_s == FWD_EX)) ||
                       (id_uses_rs2 && (sel_rs2_s == FWD_EX)));

`ifdef HAZARD_FWD_EN
  assign hazard_s = load_use_s;

  // Forwarding selects, held at the register file while in reset
  always_comb begin
    if (!reset) begin
      fwd_rs1_sel = FWD_REGFILE;
      fwd_rs2_sel = FWD_REGFILE;
    end else begin
      fwd_rs1_sel = sel_rs1_s;
      fwd_rs2_sel = sel_rs2_s;
    end
  end
`else
  // Without forwarding any used source with a live EX or MEM producer must wait;
  // a load-use is simply one case of that
  assign hazard_s = load_use_s ||
                    (id_valid && ((id_uses_rs1 && (sel_rs1_s != FWD_REGFILE)) ||
                                  (id_uses_rs2 && (sel_rs2_s != FWD_REGFILE))));
  assign fwd_rs1_sel = FWD_REGFILE;
  assign fwd_rs2_sel = FWD_REGFILE;
`endif

  // Next state and stall/bubble/flush controls; redirect outranks any stall
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    flush_s     = 1'b0;
    if (!reset) begin
      state_s     = RUN;
      flush_cnt_s = 2'd0;
    end else if (ex_redirect) begin
      bubble_s    = 1'b1;
      flush_s     = 1'b1;
      flush_cnt_s = FLUSH_RELOAD;
      if (FLUSH_RELOAD == 2'd0) begin
        state_s = RUN;
      end else begin
        state_s = FLUSH;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (hazard_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
            state_s  = LOAD_STALL;
          end else begin
            state_s  = RUN;
          end
        end
        LOAD_STALL: begin
`ifdef HAZARD_FWD_EN
          // The load has reached MEM and is forwarded from there
          state_s = RUN;
`else
          if (hazard_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
            state_s  = LOAD_STALL;
          end else begin
            state_s  = RUN;
          end
`endif
        end
        FLUSH: begin
          if (flush_cnt_r != 2'd0) begin
            bubble_s = 1'b1;
            flush_s  = 1'b1;
          end else begin
            bubble_s = 1'b0;
            flush_s  = 1'b0;
          end
          if (flush_cnt_r <= 2'd1) begin
            flush_cnt_s = 2'd0;
            state_s     = RUN;
          end else begin
            flush_cnt_s = flush_cnt_r - 2'd1;
            state_s     = FLUSH;
          end
        end
        default: begin
          state_s     = RUN;
          flush_cnt_s = 2'd0;
        end
      endcase
    end
  end

  assign stall_if  = stall_s;
  assign stall_id  = stall_s;
  assign bubble_ex = bubble_s;
  assign flush_id  = flush_s;

  // Sequencer state and flush counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= RUN;
      flush_cnt_r <= 2'd0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // One-cycle PC load pulse and the captured redirect target
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_load_r   <= 1'b0;
      pc_target_r <= '0;
    end else begin
      pc_load_r <= ex_redirect;
      if (ex_redirect) begin
        pc_target_r <= ex_redirect_target;
      end
    end
  end

  // Saturating count of cycles that lost issue to a stall or bubble
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count_r <= 16'd0;
    end else if ((stall_s || bubble_s) && (stall_count_r != 16'hFFFF)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end
  end

  assign pc_load        = pc_load_r;
  assign pc_load_target = pc_target_r;
  assign stall_count    = stall_count_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed stimulus with a rule-level reference model
// (remaining-bubble count, last-cycle-was-load-stall flag) checked every cycle,
// plus hand-computed pins. Covers both HAZARD_FWD_EN builds.
module tb_hazard_stall_unit;

  localparam int FC = 2;
  localparam int AB = 20;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ADD = 7'b0110011;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd;
  logic [6:0]    ex_opcode;
  logic          ex_write, mem_write, ex_redirect;
  logic [AB-1:0] ex_redirect_target;
  logic          stall_if, stall_id, bubble_ex, flush_id, pc_load;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
  logic [AB-1:0] pc_load_target;
  logic [15:0]   stall_count;

  int tests = 0;
  int fails = 0;

  // reference model state
  int            flush_left = 0;
  bit            after_load = 1'b0;
  logic          m_pc_load = 1'b0;
  logic [AB-1:0] m_target = '0;
  int            m_count = 0;

  always #5 clock = ~clock;

  hazard_stall_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(AB), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_write(ex_write),
    .mem_rd(mem_rd), .mem_write(mem_write),
    .ex_redirect(ex_redirect), .ex_redirect_target(ex_redirect_target),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .pc_load(pc_load), .pc_load_target(pc_load_target), .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // which in-flight stage holds the newest value of src: 0 none, 1 EX, 2 MEM
  function automatic logic [1:0] src_sel(input logic [4:0] src);
    if (ex_write && ex_rd != 5'd0 && ex_rd == src) return 2'd1;
    if (mem_write && mem_rd != 5'd0 && mem_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (reset !== 1'b1) return 2'd0;
`ifdef HAZARD_FWD_EN
    return src_sel(src);
`else
    return (src_sel(src) == 2'd3) ? 2'd3 : 2'd0;
`endif
  endfunction

  // expected {stall, bubble, flush} for the current inputs
  function automatic logic [2:0] exp_ctrl();
    bit ld;
    if (reset !== 1'b1) return 3'b000;
    if (ex_redirect) return 3'b011;
    if (flush_left > 0) return 3'b011;
    ld = id_valid && (ex_opcode == OPC_LD) && ex_write && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
`ifdef HAZARD_FWD_EN
    if (ld && !after_load) return 3'b110;
`else
    if (ld || (id_valid && ((id_uses_rs1 && src_sel(id_rs1) != 2'd0) ||
                            (id_uses_rs2 && src_sel(id_rs2) != 2'd0)))) return 3'b110;
`endif
    return 3'b000;
  endfunction

  task automatic eval_cycle();
    logic [2:0] c;
    @(negedge clock);
    c = exp_ctrl();
    chk("stall_if", 32'(stall_if), 32'(c[2]));
    chk("stall_id", 32'(stall_id), 32'(c[2]));
    chk("bubble_ex", 32'(bubble_ex), 32'(c[1]));
    chk("flush_id", 32'(flush_id), 32'(c[0]));
    chk("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(exp_fwd(id_rs1)));
    chk("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(exp_fwd(id_rs2)));
    chk("pc_load", 32'(pc_load), 32'(m_pc_load));
    chk("pc_load_target", 32'(pc_load_target), 32'(m_target));
    chk("stall_count", 32'(stall_count), 32'(m_count));
  endtask

  task automatic next_edge();
    logic [2:0] c;
    @(posedge clock);
    c = exp_ctrl();
    if (reset !== 1'b1) begin
      flush_left = 0; after_load = 1'b0; m_pc_load = 1'b0; m_target = '0; m_count = 0;
    end else begin
      if ((c[2] || c[1]) && m_count < 65535) m_count++;
      m_pc_load  = ex_redirect;
      if (ex_redirect) m_target = ex_redirect_target;
      after_load = c[2];
      if (ex_redirect) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
    end
    #1;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_opcode = 7'd0; ex_rd = 5'd0; ex_write = 1'b0;
    mem_rd = 5'd0; mem_write = 1'b0; ex_redirect = 1'b0; ex_redirect_target = '0;
  endtask

  task automatic step();
    eval_cycle();
    next_edge();
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    step();
    eval_cycle();
    chk("pin_reset_count", 32'(stall_count), 32'h0);
    chk("pin_reset_pc_load", 32'(pc_load), 32'h0);
    next_edge();
    reset = 1'b1;
    step();

    // load x5 in EX, decode reads x5
    ex_opcode = OPC_LD; ex_write = 1'b1; ex_rd = 5'd5;
    id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = 5'd5;
    eval_cycle();
    chk("pin_lu_stall_if", 32'(stall_if), 32'h1);
    chk("pin_lu_stall_id", 32'(stall_id), 32'h1);
    chk("pin_lu_bubble", 32'(bubble_ex), 32'h1);
    next_edge();
    ex_opcode = 7'd0; ex_write = 1'b0; ex_rd = 5'd0; mem_rd = 5'd5; mem_write = 1'b1;
    eval_cycle();
`ifdef HAZARD_FWD_EN
    chk("pin_lu_fwd_mem", 32'(fwd_rs1_sel), 32'h2);
    chk("pin_lu_after_stall", 32'(stall_if), 32'h0);
`else
    chk("pin_lu_fwd_off", 32'(fwd_rs1_sel), 32'h0);
    chk("pin_lu_mem_stall", 32'(stall_if), 32'h1);
`endif
    next_edge();
    mem_write = 1'b0; mem_rd = 5'd0;
    eval_cycle();
    chk("pin_lu_released", 32'(stall_if), 32'h0);
`ifdef HAZARD_FWD_EN
    chk("pin_lu_count", 32'(stall_count), 32'd1);
`else
    chk("pin_lu_count", 32'(stall_count), 32'd2);
`endif
    next_edge();
    set_idle(); step();

    // ALU producer rd=7 in EX, decode reads rs2=7
    ex_opcode = OPC_ADD; ex_write = 1'b1; ex_rd = 5'd7;
    id_valid = 1'b1; id_uses_rs2 = 1'b1; id_rs2 = 5'd7;
    eval_cycle();
`ifdef HAZARD_FWD_EN
    chk("pin_alu_fwd_ex", 32'(fwd_rs2_sel), 32'h1);
    chk("pin_alu_no_stall", 32'(stall_if), 32'h0);
`else
    chk("pin_alu_fwd_off", 32'(fwd_rs2_sel), 32'h0);
    chk("pin_alu_stall", 32'(stall_if), 32'h1);
`endif
    next_edge();
    mem_rd = 5'd7; mem_write = 1'b1;
    eval_cycle();
`ifdef HAZARD_FWD_EN
    chk("pin_ex_over_mem", 32'(fwd_rs2_sel), 32'h1);
`else
    chk("pin_ex_mem_stall", 32'(bubble_ex), 32'h1);
`endif
    next_edge();
    // only MEM holds x7 now
    ex_write = 1'b0; ex_rd = 5'd0; ex_opcode = 7'd0;
    step();
    set_idle(); step();

    // writes to x0 are never forwarded nor stalled on
    ex_opcode = OPC_LD; ex_write = 1'b1; ex_rd = 5'd0;
    mem_write = 1'b1; mem_rd = 5'd0;
    id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = 5'd0;
    eval_cycle();
    chk("pin_x0_fwd", 32'(fwd_rs1_sel), 32'h0);
    chk("pin_x0_stall", 32'(stall_if), 32'h0);
    next_edge();
    set_idle(); step();

    // redirect to 0x00400: two bubbles, pc_load one cycle later
    ex_redirect = 1'b1; ex_redirect_target = 20'h00400;
    eval_cycle();
    chk("pin_rd_bubble0", 32'(bubble_ex), 32'h1);
    chk("pin_rd_pcload0", 32'(pc_load), 32'h0);
    next_edge();
    ex_redirect = 1'b0; ex_redirect_target = 20'h0;
    eval_cycle();
    chk("pin_rd_bubble1", 32'(bubble_ex), 32'h1);
    chk("pin_rd_flush1", 32'(flush_id), 32'h1);
    chk("pin_rd_pcload1", 32'(pc_load), 32'h1);
    chk("pin_rd_target", 32'(pc_load_target), 32'h00400);
    next_edge();
    eval_cycle();
    chk("pin_rd_done", 32'(bubble_ex), 32'h0);
    chk("pin_rd_pulse_end", 32'(pc_load), 32'h0);
    next_edge();

    // redirect together with a load-use: flush only
    ex_opcode = OPC_LD; ex_write = 1'b1; ex_rd = 5'd9;
    id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = 5'd9;
    ex_redirect = 1'b1; ex_redirect_target = 20'h12345;
    eval_cycle();
    chk("pin_pri_no_stall", 32'(stall_if), 32'h0);
    chk("pin_pri_flush", 32'(flush_id), 32'h1);
    next_edge();
    ex_redirect = 1'b0;
    eval_cycle();
    chk("pin_pri_flushing", 32'(bubble_ex), 32'h1);
    chk("pin_pri_flushing_nostall", 32'(stall_if), 32'h0);
    next_edge();
    set_idle(); step();

    // redirect during FLUSH restarts the count and reloads the target
    ex_redirect = 1'b1; ex_redirect_target = 20'h00111;
    step();
    ex_redirect_target = 20'h00222;
    step();
    ex_redirect = 1'b0;
    eval_cycle();
    chk("pin_restart_target", 32'(pc_load_target), 32'h00222);
    chk("pin_restart_bubble", 32'(bubble_ex), 32'h1);
    next_edge();
    step();

    // reset in the middle of FLUSH aborts it
    ex_redirect = 1'b1; ex_redirect_target = 20'h0ABCD;
    step();
    ex_redirect = 1'b0; reset = 1'b0;
    eval_cycle();
    chk("pin_rst_forced", 32'(bubble_ex), 32'h0);
    next_edge();
    reset = 1'b1;
    eval_cycle();
    chk("pin_rst_pcload", 32'(pc_load), 32'h0);
    chk("pin_rst_count", 32'(stall_count), 32'h0);
    chk("pin_rst_bubble", 32'(bubble_ex), 32'h0);
    next_edge();

    // continuous redirects drive the counter into saturation
    ex_redirect = 1'b1; ex_redirect_target = 20'h00004;
    for (int i = 0; i < 65540; i++) step();
    ex_redirect = 1'b0;
    eval_cycle();
    chk("pin_sat_count", 32'(stall_count), 32'hFFFF);
    next_edge();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
